// File: rtl/hazard_fwd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Purpose  : Shared types for the pipeline hazard/forwarding controller:
//             EX operand forwarding selects and the MDU hold FSM states.
//  Revision : 1.0  initial release
// ============================================================================
package hazard_pkg;

    // EX operand source select: register file, EX/MEM latch, MEM/WB latch
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Multi-cycle mul/div hold machine
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_fwd_ctrl_if
//  Purpose  : Pipeline-stage register addresses/controls into the hazard
//             controller and the stall/flush/forward controls coming back.
//  Revision : 1.0  initial release
// ============================================================================
interface hazard_fwd_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int STAT_W = 16
);
    logic [ADDR_W-1:0] rs_id;
    logic [ADDR_W-1:0] rt_id;
    logic [ADDR_W-1:0] rs_ex;
    logic [ADDR_W-1:0] rt_ex;
    logic [ADDR_W-1:0] rd_ex;
    logic              reg_write_ex;
    logic              mem_read_ex;
    logic [ADDR_W-1:0] rd_mem;
    logic              reg_write_mem;
    logic [ADDR_W-1:0] rd_wb;
    logic              reg_write_wb;
    logic              branch_taken_ex;
    logic              mdu_start_ex;

    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              stall_if;
    logic              stall_id;
    logic              stall_ex;
    logic              flush_id;
    logic              flush_ex;
    logic              mdu_busy;
    logic [STAT_W-1:0] stall_cycles;

    // Pipeline side: drives stage information, consumes controls
    modport master (
        output rs_id, rt_id, rs_ex, rt_ex, rd_ex, reg_write_ex, mem_read_ex,
               rd_mem, reg_write_mem, rd_wb, reg_write_wb, branch_taken_ex,
               mdu_start_ex,
        input  fwd_a, fwd_b, stall_if, stall_id, stall_ex, flush_id, flush_ex,
               mdu_busy, stall_cycles
    );

    // Controller side
    modport slave (
        input  rs_id, rt_id, rs_ex, rt_ex, rd_ex, reg_write_ex, mem_read_ex,
               rd_mem, reg_write_mem, rd_wb, reg_write_wb, branch_taken_ex,
               mdu_start_ex,
        output fwd_a, fwd_b, stall_if, stall_id, stall_ex, flush_id, flush_ex,
               mdu_busy, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/hazard_fwd_ctrl_fwd_sel_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_sel_unit
//  Purpose  : Forwarding comparator for one EX source operand. The younger
//             producer (MEM) wins over WB; register $zero is never forwarded.
//  Revision : 1.0  initial release
// ============================================================================
module fwd_sel_unit
    import hazard_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] src_i,
    input  logic [ADDR_W-1:0] rd_mem_i,
    input  logic              reg_write_mem_i,
    input  logic [ADDR_W-1:0] rd_wb_i,
    input  logic              reg_write_wb_i,
    output fwd_sel_t          sel_o
);
    localparam logic [ADDR_W-1:0] C_ZERO = '0;

    // Pick the youngest in-flight producer of this operand
    always_comb begin
        sel_o = FWD_RF;
        if (reg_write_mem_i && (rd_mem_i != C_ZERO) && (rd_mem_i == src_i)) begin
            sel_o = FWD_MEM;
        end else if (reg_write_wb_i && (rd_wb_i != C_ZERO) && (rd_wb_i == src_i)) begin
            sel_o = FWD_WB;
        end
    end
endmodule
`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_fwd_ctrl
//  Purpose  : 5-stage pipeline hazard controller: EX operand forwarding,
//             load-use / RAW stall, taken-branch flush, MDU hold FSM and a
//             saturating stall-cycle statistic.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int FWD_EN  = 1,
    parameter int MDU_LAT = 4,
    parameter int STAT_W  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    hazard_fwd_ctrl_if.slave bus
);
    localparam int                CNT_W      = $clog2(MDU_LAT + 1);
    localparam logic [CNT_W-1:0]  C_CNT_LOAD = CNT_W'(MDU_LAT - 1);
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(1);
    localparam logic [STAT_W-1:0] C_STAT_MAX = '1;
    localparam logic [ADDR_W-1:0] C_ZERO     = '0;

    mdu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STAT_W-1:0] stat_q;

    fwd_sel_t w_sel_a;
    fwd_sel_t w_sel_b;
    logic     w_ex_hit;
    logic     w_mem_hit;
    logic     w_hazard;

    fwd_sel_unit #(.ADDR_W(ADDR_W)) u_fwd_a (
        .src_i           (bus.rs_ex),
        .rd_mem_i        (bus.rd_mem),
        .reg_write_mem_i (bus.reg_write_mem),
        .rd_wb_i         (bus.rd_wb),
        .reg_write_wb_i  (bus.reg_write_wb),
        .sel_o           (w_sel_a)
    );

    fwd_sel_unit #(.ADDR_W(ADDR_W)) u_fwd_b (
        .src_i           (bus.rt_ex),
        .rd_mem_i        (bus.rd_mem),
        .reg_write_mem_i (bus.reg_write_mem),
        .rd_wb_i         (bus.rd_wb),
        .reg_write_wb_i  (bus.reg_write_wb),
        .sel_o           (w_sel_b)
    );

    // Does the ID instruction read a register still being produced in EX / MEM
    assign w_ex_hit  = (bus.rd_ex != C_ZERO) &&
                       ((bus.rd_ex == bus.rs_id) || (bus.rd_ex == bus.rt_id));
    assign w_mem_hit = (bus.rd_mem != C_ZERO) &&
                       ((bus.rd_mem == bus.rs_id) || (bus.rd_mem == bus.rt_id));

    // With forwarding only a load result is too late; without it every
    // unretired producer blocks ID (WB is covered by write-before-read).
    assign w_hazard = (FWD_EN != 0)
                    ? (bus.mem_read_ex && w_ex_hit)
                    : ((bus.reg_write_ex && w_ex_hit) || (bus.reg_write_mem && w_mem_hit));

    // Output controls: reset > MDU hold > branch flush > hazard bubble
    always_comb begin
        bus.fwd_a    = FWD_RF;
        bus.fwd_b    = FWD_RF;
        bus.stall_if = 1'b0;
        bus.stall_id = 1'b0;
        bus.stall_ex = 1'b0;
        bus.flush_id = 1'b0;
        bus.flush_ex = 1'b0;
        bus.mdu_busy = 1'b0;
        if (!RST) begin
            if (FWD_EN != 0) begin
                bus.fwd_a = w_sel_a;
                bus.fwd_b = w_sel_b;
            end
            if (state_q == BUSY) begin
                bus.stall_if = 1'b1;
                bus.stall_id = 1'b1;
                bus.stall_ex = 1'b1;
                bus.mdu_busy = 1'b1;
            end else if (bus.branch_taken_ex) begin
                bus.flush_id = 1'b1;
                bus.flush_ex = 1'b1;
            end else if (w_hazard) begin
                bus.stall_if = 1'b1;
                bus.stall_id = 1'b1;
                bus.flush_ex = 1'b1;
            end
        end
    end

    // MDU hold FSM: a start in EX holds the pipe for MDU_LAT-1 further cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.mdu_start_ex && !bus.branch_taken_ex && (MDU_LAT > 1)) begin
                    state_d = BUSY;
                    cnt_d   = C_CNT_LOAD;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == C_CNT_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, latency counter and saturating stall statistic
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (bus.stall_if && (stat_q != C_STAT_MAX)) begin
                stat_q <= stat_q + 1'b1;
            end
        end
    end

    assign bus.stall_cycles = stat_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_fwd_ctrl
//  Purpose  : Directed scoreboard bench. dut1: forwarding on, MDU_LAT=4,
//             16-bit statistic. dut2: forwarding off, MDU_LAT=1, 2-bit
//             statistic. Each driven cycle queues its expected outputs; a
//             monitor on the falling edge pops and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_fwd_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hazard_fwd_ctrl_if #(.ADDR_W(5), .STAT_W(16)) bus1 ();
    hazard_fwd_ctrl_if #(.ADDR_W(5), .STAT_W(2))  bus2 ();

    hazard_fwd_ctrl #(.ADDR_W(5), .FWD_EN(1), .MDU_LAT(4), .STAT_W(16)) dut1 (
        .CLK (clk),
        .RST (rst),
        .bus (bus1)
    );

    hazard_fwd_ctrl #(.ADDR_W(5), .FWD_EN(0), .MDU_LAT(1), .STAT_W(2)) dut2 (
        .CLK (clk),
        .RST (rst),
        .bus (bus2)
    );

    // outs = {fwd_a, fwd_b, stall_if, stall_id, stall_ex, flush_id, flush_ex, mdu_busy, stall_cycles[15:0]}
    typedef struct packed {
        logic        d2;
        logic [95:0] name;
        logic [25:0] outs;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110010;
    localparam logic [5:0] C_BR   = 6'b000110;
    localparam logic [5:0] C_MDU  = 6'b111001;

    task automatic clr();
        bus1.rs_id = '0; bus1.rt_id = '0; bus1.rs_ex = '0; bus1.rt_ex = '0;
        bus1.rd_ex = '0; bus1.reg_write_ex = 1'b0; bus1.mem_read_ex = 1'b0;
        bus1.rd_mem = '0; bus1.reg_write_mem = 1'b0; bus1.rd_wb = '0;
        bus1.reg_write_wb = 1'b0; bus1.branch_taken_ex = 1'b0; bus1.mdu_start_ex = 1'b0;
        bus2.rs_id = '0; bus2.rt_id = '0; bus2.rs_ex = '0; bus2.rt_ex = '0;
        bus2.rd_ex = '0; bus2.reg_write_ex = 1'b0; bus2.mem_read_ex = 1'b0;
        bus2.rd_mem = '0; bus2.reg_write_mem = 1'b0; bus2.rd_wb = '0;
        bus2.reg_write_wb = 1'b0; bus2.branch_taken_ex = 1'b0; bus2.mdu_start_ex = 1'b0;
    endtask

    // Advance to just after the next rising edge with idle inputs
    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic expect_v(input logic d2, input logic [95:0] nm, input logic [1:0] fa,
                            input logic [1:0] fb, input logic [5:0] ctl, input logic [15:0] st);
        exp_t e;
        e.d2   = d2;
        e.name = nm;
        e.outs = {fa, fb, ctl, st};
        q.push_back(e);
    endtask

    // Monitor: compare the queued expectation against the selected DUT
    always @(negedge clk) begin
        exp_t        e;
        logic [25:0] act;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.d2)
                act = {bus2.fwd_a, bus2.fwd_b, bus2.stall_if, bus2.stall_id, bus2.stall_ex,
                       bus2.flush_id, bus2.flush_ex, bus2.mdu_busy, 14'b0, bus2.stall_cycles};
            else
                act = {bus1.fwd_a, bus1.fwd_b, bus1.stall_if, bus1.stall_id, bus1.stall_ex,
                       bus1.flush_id, bus1.flush_ex, bus1.mdu_busy, bus1.stall_cycles};
            total++;
            if (act !== e.outs) begin
                bad++;
                $display("FAIL %s: actual=%h required=%h", e.name, act, e.outs);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr();
        // Reset held: hazard and forwarding stimulus must be masked
        step();
        bus1.mem_read_ex = 1'b1; bus1.rd_ex = 5'd5; bus1.rt_id = 5'd5;
        bus1.rs_ex = 5'd5; bus1.rd_mem = 5'd5; bus1.reg_write_mem = 1'b1;
        expect_v(1'b0, "reset", 2'b00, 2'b00, C_NONE, 16'd0);

        step(); rst = 1'b0;
        bus1.rs_ex = 5'd3; bus1.rt_ex = 5'd4; bus1.rd_mem = 5'd3; bus1.reg_write_mem = 1'b1;
        bus1.rd_wb = 5'd4; bus1.reg_write_wb = 1'b1;
        expect_v(1'b0, "fwd_indep", 2'b10, 2'b01, C_NONE, 16'd0);

        step();
        bus1.rs_ex = 5'd7; bus1.rd_mem = 5'd7; bus1.rd_wb = 5'd7;
        bus1.reg_write_mem = 1'b1; bus1.reg_write_wb = 1'b1;
        expect_v(1'b0, "fwd_memprio", 2'b10, 2'b00, C_NONE, 16'd0);

        step();
        bus1.reg_write_mem = 1'b1; bus1.reg_write_wb = 1'b1;
        expect_v(1'b0, "fwd_zero", 2'b00, 2'b00, C_NONE, 16'd0);

        step();
        bus1.rt_ex = 5'd9; bus1.rd_wb = 5'd9; bus1.reg_write_wb = 1'b1; bus1.rd_mem = 5'd9;
        expect_v(1'b0, "fwd_wb_b", 2'b00, 2'b01, C_NONE, 16'd0);

        step();
        bus1.mem_read_ex = 1'b1; bus1.reg_write_ex = 1'b1; bus1.rd_ex = 5'd5; bus1.rt_id = 5'd5;
        expect_v(1'b0, "loaduse", 2'b00, 2'b00, C_LU, 16'd0);

        step();
        bus1.rd_mem = 5'd5; bus1.reg_write_mem = 1'b1; bus1.rt_ex = 5'd5;
        expect_v(1'b0, "lu_after", 2'b00, 2'b10, C_NONE, 16'd1);

        step();
        bus1.mem_read_ex = 1'b1; bus1.rd_ex = 5'd5; bus1.rt_id = 5'd5; bus1.branch_taken_ex = 1'b1;
        expect_v(1'b0, "lu_branch", 2'b00, 2'b00, C_BR, 16'd1);

        step();
        bus1.mem_read_ex = 1'b1; bus1.reg_write_ex = 1'b1;
        expect_v(1'b0, "lu_zero", 2'b00, 2'b00, C_NONE, 16'd1);

        step(); bus1.mdu_start_ex = 1'b1;
        expect_v(1'b0, "mdu_start", 2'b00, 2'b00, C_NONE, 16'd1);

        step(); bus1.branch_taken_ex = 1'b1;
        expect_v(1'b0, "mdu_busy1", 2'b00, 2'b00, C_MDU, 16'd1);
        step();
        bus1.mdu_start_ex = 1'b1; bus1.mem_read_ex = 1'b1; bus1.rd_ex = 5'd6; bus1.rs_id = 5'd6;
        expect_v(1'b0, "mdu_busy2", 2'b00, 2'b00, C_MDU, 16'd2);
        step();
        expect_v(1'b0, "mdu_busy3", 2'b00, 2'b00, C_MDU, 16'd3);
        step();
        expect_v(1'b0, "mdu_idle", 2'b00, 2'b00, C_NONE, 16'd4);

        step(); bus1.mdu_start_ex = 1'b1; bus1.branch_taken_ex = 1'b1;
        expect_v(1'b0, "mdu_brstart", 2'b00, 2'b00, C_BR, 16'd4);
        step();
        expect_v(1'b0, "mdu_nostart", 2'b00, 2'b00, C_NONE, 16'd4);

        // Reset arriving in the second BUSY cycle, released before the next edge
        step(); bus1.mdu_start_ex = 1'b1;
        expect_v(1'b0, "rb_start", 2'b00, 2'b00, C_NONE, 16'd4);
        step();
        expect_v(1'b0, "rb_busy1", 2'b00, 2'b00, C_MDU, 16'd4);
        step(); rst = 1'b1;
        expect_v(1'b0, "rb_reset", 2'b00, 2'b00, C_NONE, 16'd0);
        #6 rst = 1'b0;
        step();
        expect_v(1'b0, "rb_after", 2'b00, 2'b00, C_NONE, 16'd0);

        // No forwarding: RAW on a MEM producer stalls while it persists
        step();
        bus2.rd_mem = 5'd2; bus2.reg_write_mem = 1'b1; bus2.rs_id = 5'd2; bus2.rs_ex = 5'd2;
        expect_v(1'b1, "raw_1", 2'b00, 2'b00, C_LU, 16'd0);
        step();
        bus2.rd_mem = 5'd2; bus2.reg_write_mem = 1'b1; bus2.rs_id = 5'd2; bus2.rs_ex = 5'd2;
        expect_v(1'b1, "raw_2", 2'b00, 2'b00, C_LU, 16'd1);
        step();
        bus2.rd_mem = 5'd2; bus2.reg_write_mem = 1'b1; bus2.rs_id = 5'd2; bus2.rs_ex = 5'd2;
        expect_v(1'b1, "raw_3", 2'b00, 2'b00, C_LU, 16'd2);
        step();
        bus2.rd_ex = 5'd6; bus2.reg_write_ex = 1'b1; bus2.rt_id = 5'd6;
        expect_v(1'b1, "raw_ex", 2'b00, 2'b00, C_LU, 16'd3);
        step();
        bus2.rd_ex = 5'd6; bus2.reg_write_ex = 1'b1; bus2.rt_id = 5'd6;
        expect_v(1'b1, "sat", 2'b00, 2'b00, C_LU, 16'd3);
        step();
        bus2.rd_wb = 5'd2; bus2.reg_write_wb = 1'b1; bus2.rs_id = 5'd2;
        expect_v(1'b1, "raw_wb", 2'b00, 2'b00, C_NONE, 16'd3);
        step(); bus2.mdu_start_ex = 1'b1;
        expect_v(1'b1, "lat1_start", 2'b00, 2'b00, C_NONE, 16'd3);
        step();
        expect_v(1'b1, "lat1_next", 2'b00, 2'b00, C_NONE, 16'd3);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: actual=%0d pending required=0 pending", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
